// File: rtl/pll_reset_seq_pkg.sv
// rtl/pll_reset_seq_pkg.sv - state encoding and default timing constants for pll_reset_seq
package pll_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;

  localparam logic [7:0] RELOCK_MAX = 8'hFF;

endpackage

// File: rtl/pll_reset_seq_sync.sv
// rtl/pll_reset_seq_sync.sv - pll_lock_sync: multi-flop bit synchronizer for the raw PLL lock
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the raw input one stage closer to the output each clock
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // synchronizer chain, cleared by reset so lock always reads as lost at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset / lock sequencer; define PLL_LOCK_TIMEOUT_EN to enable lock-timeout retry
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] relock_count
);

  localparam int PULSE_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int STAB_W  = $clog2(LOCK_STABLE_CYCLES);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);

  // reject parameter values the counters cannot represent
  if (LOCK_STABLE_CYCLES < 2) begin : g_bad_stable
    $error("LOCK_STABLE_CYCLES must be at least 2");
  end
  if (RST_PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("RST_PULSE_CYCLES must be at least 1");
  end
  if (LOCK_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("LOCK_TIMEOUT_CYCLES must be at least 2");
  end

  logic lk;

  state_e             state_q, state_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic               pll_rst_q, pll_rst_d;
  logic               core_reset_n_q, core_reset_n_d;
  logic               ready_q, ready_d;
  logic               lock_lost_q, lock_lost_d;
  logic [7:0]         relock_count_q, relock_count_d;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  pll_lock_sync #(.STAGES(2)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  // next-state logic; counters fall back to zero whenever their state is left
  always_comb begin
    state_d        = state_q;
    pulse_cnt_d    = '0;
    stab_cnt_d     = '0;
    lock_lost_d    = 1'b0;
    relock_count_d = relock_count_q;
`ifdef PLL_LOCK_TIMEOUT_EN
    tmo_cnt_d      = '0;
`endif
    if (soft_reset) begin
      state_d = ST_PLL_RST;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (pulse_cnt_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
          else pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
        end
        ST_WAIT_LOCK: begin
          if (lk) state_d = ST_STABLE;
`ifdef PLL_LOCK_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) state_d = ST_PLL_RST;
          else tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        end
        ST_STABLE: begin
          if (!lk) state_d = ST_WAIT_LOCK;
          else if (stab_cnt_q == STAB_LAST) state_d = ST_RUN;
          else stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
        ST_RUN: begin
          if (!lk) begin
            state_d     = ST_PLL_RST;
            lock_lost_d = 1'b1;
            if (relock_count_q != RELOCK_MAX) relock_count_d = relock_count_q + 8'd1;
          end
        end
        default: state_d = ST_PLL_RST;
      endcase
    end
    pll_rst_d      = (state_d == ST_PLL_RST);
    core_reset_n_d = (state_d == ST_RUN);
    ready_d        = (state_d == ST_RUN);
  end

  // sequencer state, counters and registered outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_PLL_RST;
      pulse_cnt_q    <= '0;
      stab_cnt_q     <= '0;
      pll_rst_q      <= 1'b1;
      core_reset_n_q <= 1'b0;
      ready_q        <= 1'b0;
      lock_lost_q    <= 1'b0;
      relock_count_q <= 8'd0;
`ifdef PLL_LOCK_TIMEOUT_EN
      tmo_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pulse_cnt_q    <= pulse_cnt_d;
      stab_cnt_q     <= stab_cnt_d;
      pll_rst_q      <= pll_rst_d;
      core_reset_n_q <= core_reset_n_d;
      ready_q        <= ready_d;
      lock_lost_q    <= lock_lost_d;
      relock_count_q <= relock_count_d;
`ifdef PLL_LOCK_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
`endif
    end
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset_n = core_reset_n_q;
  assign ready        = ready_q;
  assign lock_lost    = lock_lost_q;
  assign relock_count = relock_count_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - randomized and directed bench for pll_reset_seq against a phase/age model
module tb_pll_reset_seq;

  localparam int STABLE  = 8;
  localparam int PULSE   = 4;
  localparam int TIMEOUT = 32;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst;
  logic       core_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] relock_count;

  int errors = 0;
  int checks = 0;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES  (STABLE),
    .RST_PULSE_CYCLES    (PULSE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_reset   (soft_reset),
    .pll_rst      (pll_rst),
    .core_reset_n (core_reset_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .relock_count (relock_count)
  );

  initial forever #10 refclk = ~refclk;

  // model: a phase plus the number of cycles spent in it; lock seen two edges late
  typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN} mphase_e;
  mphase_e m_phase = M_RST;
  int      m_age = 0;
  int      m_relocks = 0;
  bit      m_lost = 1'b0;
  bit      m_lk = 1'b0;
  bit      lk_d1 = 1'b0;
  bit      lk_d2 = 1'b0;

  initial forever begin
    @(posedge refclk or negedge rst_n);
    if (!rst_n) begin
      m_phase = M_RST; m_age = 0; m_relocks = 0; m_lost = 1'b0; lk_d1 = 1'b0; lk_d2 = 1'b0;
    end else begin
      m_lk = lk_d2; lk_d2 = lk_d1; lk_d1 = pll_locked; m_lost = 1'b0;
      if (soft_reset) begin
        m_phase = M_RST; m_age = 0;
      end else begin
        case (m_phase)
          M_RST: begin
            m_age++;
            if (m_age == PULSE) begin m_phase = M_WAIT; m_age = 0; end
          end
          M_WAIT: begin
            if (m_lk) begin
              m_phase = M_STAB; m_age = 0;
            end else begin
              m_age++;
`ifdef PLL_LOCK_TIMEOUT_EN
              if (m_age == TIMEOUT) begin m_phase = M_RST; m_age = 0; end
`endif
            end
          end
          M_STAB: begin
            if (!m_lk) begin
              m_phase = M_WAIT; m_age = 0;
            end else begin
              m_age++;
              if (m_age == STABLE) m_phase = M_RUN;
            end
          end
          default: begin
            if (!m_lk) begin
              m_phase = M_RST; m_age = 0; m_lost = 1'b1;
              if (m_relocks < 255) m_relocks++;
            end
          end
        endcase
      end
    end
  end

  // per-cycle comparison of every output against the model, away from the active edge
  logic [11:0] act_vec, exp_vec;
  initial forever begin
    @(negedge refclk);
    if (rst_n) begin
      act_vec = {pll_rst, core_reset_n, ready, lock_lost, relock_count};
      exp_vec = {m_phase == M_RST, m_phase == M_RUN, m_phase == M_RUN, m_lost, m_relocks[7:0]};
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: got rst/crn/rdy/lost=%b relock=%0d, expected rst/crn/rdy/lost=%b relock=%0d",
                 $time, act_vec[11:8], act_vec[7:0], exp_vec[11:8], exp_vec[7:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!ready && n < budget) begin step(); n++; end
    if (!ready) begin
      errors++; checks++;
      $display("FAIL wait_ready: ready not seen within %0d cycles", budget);
    end
  endtask

  int n, hi, lost, rises, r1, r2, k, burst;
  bit prev, seen_ready;

  initial begin
    // reset values while rst_n is held low
    pll_locked = 1'b1;
    #25;
    check("reset_pll_rst", pll_rst, 1);
    check("reset_core_reset_n", core_reset_n, 0);
    check("reset_ready", ready, 0);
    check("reset_lock_lost", lock_lost, 0);
    check("reset_relock_count", relock_count, 0);

    // clean start with lock present: 4-cycle pulse, RUN on cycle 13
    @(posedge refclk); #1; rst_n = 1'b1;
    n = 0; hi = 0;
    while (!ready && n < 100) begin
      if (pll_rst) hi++;
      step(); n++;
    end
    check("first_lock_latency", n, 13);
    check("first_pulse_width", hi, 4);
    check("first_relock_count", relock_count, 0);

    // lock dropped for 3 cycles in RUN
    n = 0; hi = 0; lost = 0;
    pll_locked = 1'b0;
    repeat (3) begin step(); n++; hi += pll_rst; lost += lock_lost; end
    pll_locked = 1'b1;
    while (!ready && n < 100) begin step(); n++; hi += pll_rst; lost += lock_lost; end
    check("drop_relock_latency", n, 16);
    check("drop_lock_lost_pulses", lost, 1);
    check("drop_pulse_width", hi, 4);
    check("drop_relock_count", relock_count, 1);

    // one-cycle glitch seen at stable count 5
    soft_reset = 1'b1; step(); soft_reset = 1'b0;
    n = 0;
    while (!(m_phase == M_STAB && m_age == 3) && n < 50) begin step(); n++; end
    pll_locked = 1'b0; step(); pll_locked = 1'b1; step(); step();
    check("glitch_ready_low", ready, 0);
    wait_ready(50, n);
    check("glitch_relock_latency", n, 9);

    // soft_reset on the same edge the synced lock falls
    pll_locked = 1'b0; step(); step();
    soft_reset = 1'b1; step(); soft_reset = 1'b0;
    check("soft_pll_rst", pll_rst, 1);
    check("soft_lock_lost", lock_lost, 0);
    pll_locked = 1'b1;
    lost = 0; n = 0;
    while (!ready && n < 100) begin step(); n++; lost += lock_lost; end
    check("soft_no_lock_lost", lost, 0);
    check("soft_relock_count", relock_count, 1);

    // lock held low: periodic retry pulses, never ready
    soft_reset = 1'b1; pll_locked = 1'b0; step(); soft_reset = 1'b0;
    prev = pll_rst; hi = pll_rst; n = 0; rises = 0; r1 = 0; r2 = 0; seen_ready = 1'b0;
    repeat (100) begin
      step(); n++;
      hi += pll_rst;
      if (pll_rst && !prev) begin
        rises++;
        if (rises == 1) r1 = n; else if (rises == 2) r2 = n;
      end
      prev = pll_rst;
      if (ready) seen_ready = 1'b1;
    end
    check("nolock_ready_never", seen_ready, 0);
`ifdef PLL_LOCK_TIMEOUT_EN
    check("nolock_first_retry", r1, 36);
    check("nolock_second_retry", r2, 72);
    check("nolock_high_cycles", hi, 12);
`else
    check("nolock_no_retry", rises, 0);
    check("nolock_high_cycles", hi, 4);
`endif
    pll_locked = 1'b1;

    // randomized lock bursts and soft resets
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) begin
        pll_locked = 1'b0; burst--;
      end else if ($urandom_range(0, 99) < 3) begin
        pll_locked = 1'b0; burst = $urandom_range(0, 40);
      end else begin
        pll_locked = 1'b1;
      end
      soft_reset = ($urandom_range(0, 199) == 0);
      step();
    end
    soft_reset = 1'b0; pll_locked = 1'b1;
    wait_ready(200, n);

    // 300 lock losses saturate the counter
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      k = 0;
      while (ready && k < 10) begin step(); k++; end
      pll_locked = 1'b1;
      wait_ready(100, n);
    end
    check("relock_saturated", relock_count, 255);

    // asynchronous reset in the middle of a RUN cycle
    #4; rst_n = 1'b0; #1;
    check("async_pll_rst", pll_rst, 1);
    check("async_core_reset_n", core_reset_n, 0);
    check("async_ready", ready, 0);
    check("async_lock_lost", lock_lost, 0);
    check("async_relock_count", relock_count, 0);
    step(); step();
    rst_n = 1'b1;
    wait_ready(100, n);
    check("post_reset_latency", n, 13);
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
